// File: rtl/mem_pkg.sv
// Shared memory-stage encodings: op/size codes, FSM states, byte-lane layout and
// store lane helpers. The execute stage uses the same encodings.
package mem_pkg;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int DATA_W    = NUM_LANES * LANE_W;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10,
    MEM_RSVD  = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      SZ_WORD: is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [NUM_LANES-1:0] store_strb(input mem_size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: store_strb = 4'b0001 << off;
      SZ_HALF: store_strb = off[1] ? 4'b1100 : 4'b0011;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  // Store data is replicated across lanes so the strobe alone selects placement.
  function automatic logic [DATA_W-1:0] store_data(input mem_size_e size, input logic [DATA_W-1:0] din);
    case (size)
      SZ_BYTE: store_data = {NUM_LANES{din[LANE_W-1:0]}};
      SZ_HALF: store_data = {2{din[2*LANE_W-1:0]}};
      default: store_data = din;
    endcase
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage and the data memory.
interface mem_stage_if #(parameter int ADDR_W = 32);
  logic              dmemReq;
  logic              dmemWe;
  logic [ADDR_W-1:0] dmemAddr;
  logic [31:0]       dmemWdata;
  logic [3:0]        dmemWstrb;
  logic              dmemAck;
  logic [31:0]       dmemRdata;

  modport master (
    output dmemReq, dmemWe, dmemAddr, dmemWdata, dmemWstrb,
    input  dmemAck, dmemRdata
  );

  modport slave (
    input  dmemReq, dmemWe, dmemAddr, dmemWdata, dmemWstrb,
    output dmemAck, dmemRdata
  );
endinterface

// File: rtl/mem_load_format.sv
// Load data formatting: shift the addressed lane down, then sign/zero-extend.
module mem_load_format
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        off,
  input  mem_size_e         size,
  input  logic              uns,
  output logic [DATA_W-1:0] data
);
  logic [DATA_W-1:0] lane;

  always_comb begin
    lane = rdata >> {off, 3'b000};
    case (size)
      SZ_BYTE: data = {{(DATA_W-LANE_W){~uns & lane[LANE_W-1]}}, lane[LANE_W-1:0]};
      SZ_HALF: data = {{(DATA_W-2*LANE_W){~uns & lane[2*LANE_W-1]}}, lane[2*LANE_W-1:0]};
      default: data = lane;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues aligned loads/stores, holds the pipe until the
// memory acks, formats load data and drives writeback.
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] aluIn,
  input  logic [1:0]  memOpIn,
  input  logic [1:0]  memSizeIn,
  input  logic        loadUnsigned,
  input  logic [31:0] memDin,
  input  logic [4:0]  rdIn,
  input  logic        regWriteIn,
  mem_stage_if.master dmem,
  output logic [31:0] wbData,
  output logic [4:0]  wbRd,
  output logic        wbEn,
  output logic        stallOut,
  output logic        misalign
);
  mem_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic              wb_en_q, wb_en_d;
  logic              misalign_q, misalign_d;
  logic [1:0]        off_q, off_d;
  mem_size_e         size_q, size_d;
  logic              uns_q, uns_d;
  logic [4:0]        rd_q, rd_d;
  logic              regwr_q, regwr_d;

  logic [31:0] load_data;
  mem_size_e   size_in;
  logic        is_mem;

  assign size_in = mem_size_e'(memSizeIn);
  assign is_mem  = (memOpIn == MEM_LOAD) || (memOpIn == MEM_STORE);

  mem_load_format u_fmt (
    .rdata (dmem.dmemRdata),
    .off   (off_q),
    .size  (size_q),
    .uns   (uns_q),
    .data  (load_data)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_en_d    = 1'b0;
    misalign_d = 1'b0;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rd_d       = rd_q;
    regwr_d    = regwr_q;
    case (state_q)
      ST_IDLE: begin
        if (!is_mem) begin
          wb_data_d = aluIn;
          wb_rd_d   = rdIn;
          wb_en_d   = regWriteIn;
        end else if (is_misaligned(size_in, aluIn[1:0])) begin
          misalign_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
          req_d   = 1'b1;
          we_d    = (memOpIn == MEM_STORE);
          addr_d  = {aluIn[ADDR_W-1:2], 2'b00};
          wstrb_d = (memOpIn == MEM_STORE) ? store_strb(size_in, aluIn[1:0]) : 4'b0000;
          wdata_d = (memOpIn == MEM_STORE) ? store_data(size_in, memDin) : 32'h0;
          off_d   = aluIn[1:0];
          size_d  = size_in;
          uns_d   = loadUnsigned;
          rd_d    = rdIn;
          regwr_d = regWriteIn;
        end
      end
      ST_WAIT: begin
        // Bus outputs are frozen until the ack is seen.
        if (dmem.dmemAck) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          if (!we_q) begin
            wb_data_d = load_data;
            wb_rd_d   = rd_q;
            wb_en_d   = regwr_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_en_q    <= 1'b0;
      misalign_q <= 1'b0;
      off_q      <= '0;
      size_q     <= SZ_BYTE;
      uns_q      <= 1'b0;
      rd_q       <= '0;
      regwr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_en_q    <= wb_en_d;
      misalign_q <= misalign_d;
      off_q      <= off_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      rd_q       <= rd_d;
      regwr_q    <= regwr_d;
    end
  end

  assign dmem.dmemReq   = req_q;
  assign dmem.dmemWe    = we_q;
  assign dmem.dmemAddr  = addr_q;
  assign dmem.dmemWdata = wdata_q;
  assign dmem.dmemWstrb = wstrb_q;
  assign wbData         = wb_data_q;
  assign wbRd           = wb_rd_q;
  assign wbEn           = wb_en_q;
  assign misalign       = misalign_q;
  assign stallOut       = (state_q == ST_WAIT);
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs change on the falling edge, outputs are
// checked on the falling edge after each rising edge.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] aluIn;
  logic [1:0]  memOpIn, memSizeIn;
  logic        loadUnsigned;
  logic [31:0] memDin;
  logic [4:0]  rdIn;
  logic        regWriteIn;
  logic [31:0] wbData;
  logic [4:0]  wbRd;
  logic        wbEn, stallOut, misalign;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage_if #(.ADDR_W(32)) dmem ();

  mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .aluIn(aluIn), .memOpIn(memOpIn), .memSizeIn(memSizeIn),
    .loadUnsigned(loadUnsigned), .memDin(memDin), .rdIn(rdIn), .regWriteIn(regWriteIn),
    .dmem(dmem), .wbData(wbData), .wbRd(wbRd), .wbEn(wbEn),
    .stallOut(stallOut), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bubble();
    memOpIn = 2'b00; regWriteIn = 1'b0; aluIn = 32'h0; rdIn = 5'd0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] sz, input logic [31:0] a,
                       input logic uns, input logic [31:0] din, input logic [4:0] rd);
    memOpIn = op; memSizeIn = sz; aluIn = a; loadUnsigned = uns;
    memDin = din; rdIn = rd; regWriteIn = 1'b1;
  endtask

  // Issue a load, ack on the first WAIT cycle; returns writeback observed after the ack edge.
  task automatic do_load(input logic [1:0] sz, input logic [31:0] a, input logic uns,
                         input logic [31:0] rdata, output logic [31:0] d, output logic en);
    issue(2'b01, sz, a, uns, 32'h0, 5'd9);
    tick();
    bubble();
    dmem.dmemAck = 1'b1; dmem.dmemRdata = rdata;
    tick();
    dmem.dmemAck = 1'b0;
    d = wbData; en = wbEn;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_cmp++; if (stallOut !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", stallOut); end
    n_cmp++; if (dmem.dmemReq !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", dmem.dmemReq); end
    n_cmp++; if ({dmem.dmemWe, dmem.dmemWstrb} !== 5'h0) begin n_err++; $display("FAIL reset_we_strb got=%h exp=0", {dmem.dmemWe, dmem.dmemWstrb}); end
    n_cmp++; if (dmem.dmemAddr !== 32'h0 || dmem.dmemWdata !== 32'h0) begin n_err++; $display("FAIL reset_addr_wdata got=%h/%h exp=0", dmem.dmemAddr, dmem.dmemWdata); end
    n_cmp++; if ({wbEn, misalign, wbRd} !== 7'h0 || wbData !== 32'h0) begin n_err++; $display("FAIL reset_wb got=%b/%b/%h/%h exp=0", wbEn, misalign, wbRd, wbData); end
    reset = 1'b0;
  endtask

  task automatic test_load_byte();
    issue(2'b01, 2'b00, 32'h0000_1003, 1'b0, 32'h0, 5'd3);
    tick();
    bubble();
    n_cmp++; if (dmem.dmemReq !== 1'b1 || dmem.dmemWe !== 1'b0) begin n_err++; $display("FAIL lb_req got=%b we=%b exp=1/0", dmem.dmemReq, dmem.dmemWe); end
    n_cmp++; if (dmem.dmemAddr !== 32'h0000_1000) begin n_err++; $display("FAIL lb_addr got=%h exp=00001000", dmem.dmemAddr); end
    n_cmp++; if (stallOut !== 1'b1 || wbEn !== 1'b0) begin n_err++; $display("FAIL lb_wait got stall=%b wbEn=%b exp=1/0", stallOut, wbEn); end
    dmem.dmemAck = 1'b1; dmem.dmemRdata = 32'h80FF_FF12;
    tick();
    dmem.dmemAck = 1'b0;
    n_cmp++; if (wbEn !== 1'b1 || wbData !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_wb got en=%b data=%h exp=1/ffffff80", wbEn, wbData); end
    n_cmp++; if (wbRd !== 5'd3 || dmem.dmemReq !== 1'b0 || stallOut !== 1'b0) begin n_err++; $display("FAIL lb_done got rd=%0d req=%b stall=%b exp=3/0/0", wbRd, dmem.dmemReq, stallOut); end
    tick();
    n_cmp++; if (wbEn !== 1'b0) begin n_err++; $display("FAIL lb_pulse got=%b exp=0", wbEn); end
  endtask

  task automatic test_store_half();
    issue(2'b10, 2'b01, 32'h0000_2002, 1'b0, 32'h0000_ABCD, 5'd4);
    tick();
    bubble();
    n_cmp++; if (dmem.dmemWstrb !== 4'b1100 || dmem.dmemWdata !== 32'hABCD_ABCD) begin n_err++; $display("FAIL sh_bus got strb=%b data=%h exp=1100/abcdabcd", dmem.dmemWstrb, dmem.dmemWdata); end
    n_cmp++; if (dmem.dmemWe !== 1'b1 || dmem.dmemAddr !== 32'h0000_2000) begin n_err++; $display("FAIL sh_we_addr got=%b/%h exp=1/00002000", dmem.dmemWe, dmem.dmemAddr); end
    dmem.dmemAck = 1'b1;
    tick();
    dmem.dmemAck = 1'b0;
    n_cmp++; if (wbEn !== 1'b0 || dmem.dmemReq !== 1'b0 || stallOut !== 1'b0) begin n_err++; $display("FAIL sh_done got wbEn=%b req=%b stall=%b exp=0/0/0", wbEn, dmem.dmemReq, stallOut); end
    // byte store at offset 1
    issue(2'b10, 2'b00, 32'h0000_3001, 1'b0, 32'h1234_565A, 5'd4);
    tick();
    bubble();
    n_cmp++; if (dmem.dmemWstrb !== 4'b0010 || dmem.dmemWdata !== 32'h5A5A_5A5A) begin n_err++; $display("FAIL sb_bus got strb=%b data=%h exp=0010/5a5a5a5a", dmem.dmemWstrb, dmem.dmemWdata); end
    dmem.dmemAck = 1'b1;
    tick();
    dmem.dmemAck = 1'b0;
    // word store
    issue(2'b10, 2'b10, 32'h0000_3004, 1'b0, 32'hCAFE_F00D, 5'd4);
    tick();
    bubble();
    n_cmp++; if (dmem.dmemWstrb !== 4'b1111 || dmem.dmemWdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL sw_bus got strb=%b data=%h exp=1111/cafef00d", dmem.dmemWstrb, dmem.dmemWdata); end
    dmem.dmemAck = 1'b1;
    tick();
    dmem.dmemAck = 1'b0;
  endtask

  task automatic test_misalign();
    issue(2'b01, 2'b10, 32'h0000_0006, 1'b0, 32'h0, 5'd5);
    tick();
    bubble();
    n_cmp++; if (misalign !== 1'b1 || dmem.dmemReq !== 1'b0) begin n_err++; $display("FAIL mis_word got mis=%b req=%b exp=1/0", misalign, dmem.dmemReq); end
    n_cmp++; if (stallOut !== 1'b0 || wbEn !== 1'b0) begin n_err++; $display("FAIL mis_state got stall=%b wbEn=%b exp=0/0", stallOut, wbEn); end
    tick();
    n_cmp++; if (misalign !== 1'b0 || dmem.dmemReq !== 1'b0) begin n_err++; $display("FAIL mis_pulse got mis=%b req=%b exp=0/0", misalign, dmem.dmemReq); end
    issue(2'b10, 2'b01, 32'h0000_0011, 1'b0, 32'h0, 5'd5);
    tick();
    bubble();
    n_cmp++; if (misalign !== 1'b1 || stallOut !== 1'b0) begin n_err++; $display("FAIL mis_half got mis=%b stall=%b exp=1/0", misalign, stallOut); end
    issue(2'b01, 2'b11, 32'h0000_0020, 1'b0, 32'h0, 5'd5);
    tick();
    bubble();
    n_cmp++; if (misalign !== 1'b1 || dmem.dmemReq !== 1'b0) begin n_err++; $display("FAIL mis_size got mis=%b req=%b exp=1/0", misalign, dmem.dmemReq); end
    tick();
  endtask

  task automatic test_load_half_delay();
    int stall_cycles = 0;
    issue(2'b01, 2'b01, 32'h0000_0010, 1'b1, 32'h0, 5'd7);
    tick();
    bubble();
    dmem.dmemRdata = 32'h1234_F00D;
    for (int i = 0; i < 3; i++) begin
      if (stallOut === 1'b1) stall_cycles++;
      n_cmp++; if (dmem.dmemReq !== 1'b1 || dmem.dmemAddr !== 32'h0000_0010) begin n_err++; $display("FAIL lh_hold got req=%b addr=%h exp=1/00000010", dmem.dmemReq, dmem.dmemAddr); end
      tick();
    end
    if (stallOut === 1'b1) stall_cycles++;
    dmem.dmemAck = 1'b1;
    tick();
    dmem.dmemAck = 1'b0;
    if (stallOut === 1'b1) stall_cycles++;
    n_cmp++; if (stall_cycles !== 4) begin n_err++; $display("FAIL lh_stall got=%0d exp=4", stall_cycles); end
    n_cmp++; if (wbEn !== 1'b1 || wbData !== 32'h0000_F00D || wbRd !== 5'd7) begin n_err++; $display("FAIL lh_wb got en=%b data=%h rd=%0d exp=1/0000f00d/7", wbEn, wbData, wbRd); end
  endtask

  task automatic test_load_formats();
    logic [31:0] d;
    logic        en;
    do_load(2'b10, 32'h0000_4000, 1'b0, 32'hDEAD_BEEF, d, en);
    n_cmp++; if (en !== 1'b1 || d !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lw got en=%b data=%h exp=1/deadbeef", en, d); end
    do_load(2'b00, 32'h0000_4002, 1'b1, 32'h0085_0000, d, en);
    n_cmp++; if (en !== 1'b1 || d !== 32'h0000_0085) begin n_err++; $display("FAIL lbu got en=%b data=%h exp=1/00000085", en, d); end
    do_load(2'b01, 32'h0000_4002, 1'b0, 32'h8001_0000, d, en);
    n_cmp++; if (en !== 1'b1 || d !== 32'hFFFF_8001) begin n_err++; $display("FAIL lh_signed got en=%b data=%h exp=1/ffff8001", en, d); end
    do_load(2'b00, 32'h0000_4001, 1'b0, 32'h0000_7F00, d, en);
    n_cmp++; if (en !== 1'b1 || d !== 32'h0000_007F) begin n_err++; $display("FAIL lb_pos got en=%b data=%h exp=1/0000007f", en, d); end
  endtask

  task automatic test_reset_in_wait();
    issue(2'b01, 2'b10, 32'h0000_5000, 1'b0, 32'h0, 5'd8);
    tick();
    bubble();
    tick();
    n_cmp++; if (stallOut !== 1'b1 || dmem.dmemReq !== 1'b1) begin n_err++; $display("FAIL rw_pre got stall=%b req=%b exp=1/1", stallOut, dmem.dmemReq); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (dmem.dmemReq !== 1'b0 || stallOut !== 1'b0) begin n_err++; $display("FAIL rw_reset got req=%b stall=%b exp=0/0", dmem.dmemReq, stallOut); end
    dmem.dmemAck = 1'b1; dmem.dmemRdata = 32'h1111_2222;
    tick();
    dmem.dmemAck = 1'b0;
    n_cmp++; if (wbEn !== 1'b0 || stallOut !== 1'b0 || dmem.dmemReq !== 1'b0) begin n_err++; $display("FAIL rw_ack got wbEn=%b stall=%b req=%b exp=0/0/0", wbEn, stallOut, dmem.dmemReq); end
  endtask

  task automatic test_back_to_back();
    memOpIn = 2'b00; regWriteIn = 1'b1; aluIn = 32'd5; rdIn = 5'd1;
    tick();
    n_cmp++; if (wbEn !== 1'b1 || wbData !== 32'd5 || wbRd !== 5'd1 || stallOut !== 1'b0) begin n_err++; $display("FAIL b2b_first got en=%b data=%h rd=%0d stall=%b exp=1/5/1/0", wbEn, wbData, wbRd, stallOut); end
    memOpIn = 2'b11; aluIn = 32'd7; rdIn = 5'd2;
    tick();
    n_cmp++; if (wbEn !== 1'b1 || wbData !== 32'd7 || wbRd !== 5'd2 || stallOut !== 1'b0) begin n_err++; $display("FAIL b2b_second got en=%b data=%h rd=%0d stall=%b exp=1/7/2/0", wbEn, wbData, wbRd, stallOut); end
    regWriteIn = 1'b0; memOpIn = 2'b00; aluIn = 32'd9;
    tick();
    n_cmp++; if (wbEn !== 1'b0 || wbData !== 32'd9 || dmem.dmemReq !== 1'b0) begin n_err++; $display("FAIL b2b_nowr got en=%b data=%h req=%b exp=0/9/0", wbEn, wbData, dmem.dmemReq); end
    bubble();
  endtask

  initial begin
    reset = 1'b1; bubble(); memSizeIn = 2'b00; loadUnsigned = 1'b0; memDin = 32'h0;
    dmem.dmemAck = 1'b0; dmem.dmemRdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_load_half_delay();
    test_load_formats();
    test_reset_in_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
